// File: rtl/tl45_pkg.sv
// tl45_pkg: shared instruction field positions, decoded-instruction record and decode FSM states.
package tl45_pkg;
  localparam int OPC_MSB  = 31;
  localparam int OPC_LSB  = 27;
  localparam int IMMF_BIT = 26;
  localparam int FN_MSB   = 25;
  localparam int FN_LSB   = 24;
  localparam int RD_MSB   = 23;
  localparam int RD_LSB   = 20;
  localparam int RS1_MSB  = 19;
  localparam int RS1_LSB  = 16;
  localparam int RS2_MSB  = 15;
  localparam int RS2_LSB  = 12;
  localparam int IMM_MSB  = 15;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  opcode;
    logic        imm_flag;
    logic [1:0]  fn;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [31:0] imm32;
    logic        writes_rd;
  } tl45_dr_t;

  typedef enum logic {DR_RUN, DR_INTERLOCK} dr_state_e;
endpackage

// File: rtl/tl45_inst_fields.sv
// tl45_inst_fields: combinational field split and immediate extension of one instruction word.
module tl45_inst_fields
  import tl45_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  output tl45_dr_t    f_o
);
  always_comb begin
    f_o.pc        = pc_i;
    f_o.opcode    = inst_i[OPC_MSB:OPC_LSB];
    f_o.imm_flag  = inst_i[IMMF_BIT];
    f_o.fn        = inst_i[FN_MSB:FN_LSB];
    f_o.rd        = inst_i[RD_MSB:RD_LSB];
    f_o.rs1       = inst_i[RS1_MSB:RS1_LSB];
    f_o.rs2       = inst_i[RS2_MSB:RS2_LSB];
    // fn[1] selects logical ops, which take an unsigned immediate
    f_o.imm32     = inst_i[FN_MSB] ? {16'h0, inst_i[IMM_MSB:0]} : {{16{inst_i[IMM_MSB]}}, inst_i[IMM_MSB:0]};
    f_o.writes_rd = |inst_i[RD_MSB:RD_LSB];
  end
endmodule

// File: rtl/tl45_decode.sv
// tl45_decode: decode register with load-use interlock, downstream stall and flush handling.
module tl45_decode
  import tl45_pkg::*;
#(
  parameter logic [4:0] LOAD_OPCODE      = 5'h14,
  parameter int         LOAD_USE_BUBBLES = 1
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_pipe_stall,
  input  logic        i_flush,
  input  logic        i_buf_valid,
  input  logic [31:0] i_buf_pc,
  input  logic [31:0] i_buf_inst,
  output logic        o_fetch_stall,
  output logic        o_dr_valid,
  output logic [31:0] o_dr_pc,
  output logic [4:0]  o_dr_opcode,
  output logic        o_dr_imm_flag,
  output logic [1:0]  o_dr_fn,
  output logic [3:0]  o_dr_rd,
  output logic [3:0]  o_dr_rs1,
  output logic [3:0]  o_dr_rs2,
  output logic [31:0] o_dr_imm32,
  output logic        o_dr_writes_rd
);
  localparam logic [2:0] BUB_INIT = 3'(LOAD_USE_BUBBLES - 1);

  tl45_dr_t  in_f, dr_q;
  logic      valid_q, hazard;
  dr_state_e state_q;
  logic [2:0] cnt_q;

  tl45_inst_fields u_fields (.pc_i(i_buf_pc), .inst_i(i_buf_inst), .f_o(in_f));

  assign hazard = valid_q && dr_q.opcode == LOAD_OPCODE && dr_q.rd != '0 && i_buf_valid &&
                  (in_f.rs1 == dr_q.rd || (!in_f.imm_flag && in_f.rs2 == dr_q.rd));
  assign o_fetch_stall = i_pipe_stall | (state_q == DR_INTERLOCK) | (state_q == DR_RUN && hazard);

  // The hazard cycle itself inserts the first bubble; INTERLOCK inserts the rest.
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      dr_q    <= '0;
      valid_q <= 1'b0;
      state_q <= DR_RUN;
      cnt_q   <= '0;
    end else if (i_flush) begin
      valid_q <= 1'b0;
      state_q <= DR_RUN;
      cnt_q   <= '0;
    end else if (!i_pipe_stall) begin
      if (state_q == DR_INTERLOCK) begin
        valid_q <= 1'b0;
        cnt_q   <= cnt_q - 3'd1;
        state_q <= (cnt_q <= 3'd1) ? DR_RUN : DR_INTERLOCK;
      end else if (hazard) begin
        valid_q <= 1'b0;
        cnt_q   <= BUB_INIT;
        state_q <= (BUB_INIT == 3'd0) ? DR_RUN : DR_INTERLOCK;
      end else begin
        valid_q <= i_buf_valid;
        dr_q    <= in_f;
      end
    end

  assign o_dr_valid     = valid_q;
  assign o_dr_pc        = dr_q.pc;
  assign o_dr_opcode    = dr_q.opcode;
  assign o_dr_imm_flag  = dr_q.imm_flag;
  assign o_dr_fn        = dr_q.fn;
  assign o_dr_rd        = dr_q.rd;
  assign o_dr_rs1       = dr_q.rs1;
  assign o_dr_rs2       = dr_q.rs2;
  assign o_dr_imm32     = dr_q.imm32;
  assign o_dr_writes_rd = dr_q.writes_rd;
endmodule
